cpu_run_control: RTL and testbench
==================================

# cpu_run_control

Parametrised run-control block that replaces the fixed slow/mid clock dividers and the two-input CPU clock mux with a single-clock engine. It produces a one-cycle clock-enable pulse for the RISC-V core at a programmable rate and supports run, halt and N-cycle single-step modes. Requests come from the Debug Module wishbone slave over a request/ack handshake. Sits between the DM slave and `riscvsingle`, which consumes `cpu_ce_o` as its clock enable.

## Interface
- `DIV_WIDTH`, 32, width of the divider value and counter.
- `DEFAULT_DIV`, 27000000, divider loaded on reset (1 Hz at 27 MHz).
- `STEP_WIDTH`, 16, width of the step count.
- `clk_i` in 1: system clock, the only clock.
- `rst_i` in 1: synchronous, active-high reset.
- `div_i` in DIV_WIDTH: new divider value. 0 is treated as 1.
- `div_load_i` in 1: load `div_i` this cycle.
- `halt_req_i` in 1: request HALT, sampled each cycle.
- `resume_req_i` in 1: request RUN.
- `step_req_i` in 1: request STEP of `step_count_i` enables.
- `step_count_i` in STEP_WIDTH: number of enables to issue. 0 is treated as 1.
- `cpu_ce_o` out 1: registered one-cycle CPU enable pulse.
- `ack_o` out 1: one-cycle pulse acknowledging any accepted request.
- `halted_o` out 1: state == HALT.
- `step_done_o` out 1: one-cycle pulse when a STEP completes.
- `tick_count_o` out 32: count of `cpu_ce_o` pulses, wraps modulo 2^32.

## Operation
- States are RUN, HALT and STEP. Reset enters RUN, with divider = `DEFAULT_DIV` (eff, 0→1), counter = 0 and remaining = 0.
- Divider counter:
  - Counts only in RUN and STEP. It is cleared on every state entry and on `div_load_i`.
  - When counter == div_eff−1: counter ← 0 and `cpu_ce_o` ← 1.
  - In every other case `cpu_ce_o` ← 0.
- `div_load_i` is accepted in any state. div_eff = max(`div_i`, 1). It does not pulse `ack_o`.
- Request priority in a single cycle is halt > step > resume. Only the highest-priority request is accepted. It pulses `ack_o` once.
- Transitions:
  - Halt, from any state → HALT. In STEP this aborts the step, sets remaining ← 0 and does not pulse `step_done_o`.
  - Resume, from HALT → RUN. In RUN it is a no-op that is still acked. In STEP it is a no-op that is still acked, and the step continues.
  - Step, from HALT → STEP with remaining ← max(`step_count_i`, 1). In RUN or STEP it is acked and otherwise ignored.
  - In STEP, each `cpu_ce_o` pulse decrements remaining. The pulse that takes remaining to 0 causes STEP → HALT on the next edge.
- `tick_count_o` increments on every `cpu_ce_o` pulse and wraps from 0xFFFFFFFF to 0. It is cleared only by reset.

## Timing
- Reset values:
  - `cpu_ce_o` = 0, `ack_o` = 0, `step_done_o` = 0.
  - `halted_o` = 0.
  - `tick_count_o` = 0.
- A request sampled high at edge k:
  - The new state, `ack_o` and `halted_o` are visible after edge k (cycle k+1).
  - `cpu_ce_o` is 0 in cycle k+1 when the new state is HALT.
- Entering RUN or STEP in cycle T means counter = 0 in cycle T. The first `cpu_ce_o` is high in cycle T+div_eff.
  - With div_eff = 1, `cpu_ce_o` is high every cycle from T+1.
- The period between successive pulses is exactly div_eff cycles. The pulse width is 1 cycle.
- When the last STEP pulse is high in cycle c:
  - `halted_o` = 1 in cycle c+1.
  - `step_done_o` is high in cycle c+1 only.
  - `cpu_ce_o` = 0 in cycle c+1.
- A halt that is accepted in the same cycle the counter hits div_eff−1 suppresses the pulse: HALT wins and no `cpu_ce_o` is issued.
- `rst_i` asserted mid-STEP or mid-period behaves exactly as reset: RUN, with no `step_done_o`.
- A request held high for several cycles is re-accepted every cycle. The requester must deassert on `ack_o`.

## Test plan
- Reset, `DEFAULT_DIV` overridden to 4 → `cpu_ce_o` high in cycles 4, 8, 12 after reset release; `halted_o` = 0; `tick_count_o` = 3 after cycle 12.
- In RUN, div = 4, pulse `halt_req_i` at counter = 3 → no pulse that cycle, `ack_o` and `halted_o` high next cycle, no `cpu_ce_o` for the following 20 cycles.
- HALT, `step_count_i` = 3, div = 2 → `cpu_ce_o` at T+2, T+4, T+6; `step_done_o` and `halted_o` at T+7; `tick_count_o` incremented by 3.
- HALT, `step_count_i` = 0 → exactly one `cpu_ce_o`, then `step_done_o`. Then `halt_req_i` and `step_req_i` in the same cycle from HALT → halt accepted, single `ack_o`, state remains HALT.
- In STEP with count 5, `halt_req_i` after the 2nd pulse → HALT next cycle, no `step_done_o`, `tick_count_o` += 2.
- `div_load_i` with `div_i` = 0 in RUN → `cpu_ce_o` high every cycle starting next cycle. Preload `tick_count_o` near 0xFFFFFFFF by forcing the counter → wraps to 0. `rst_i` mid-step → all outputs return to reset values.

Source files
------------

// File: rtl/cpu_run_control.sv
// Run-control engine: divides clk_i into a one-cycle CPU enable, with run / halt / N-step modes.
// Latency: requests take effect one edge after sampling; first enable div_eff cycles after entering RUN/STEP.
// Backpressure: none; every request is acked for one cycle, and the requester drops it on ack_o.
module cpu_run_control #(
  parameter int unsigned DIV_WIDTH   = 32,
  parameter int unsigned DEFAULT_DIV = 27000000,
  parameter int unsigned STEP_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  div_load_i,
  input  logic                  halt_req_i,
  input  logic                  resume_req_i,
  input  logic                  step_req_i,
  input  logic [STEP_WIDTH-1:0] step_count_i,
  output logic                  cpu_ce_o,
  output logic                  ack_o,
  output logic                  halted_o,
  output logic                  step_done_o,
  output logic [31:0]           tick_count_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0]  DIV_ONE     = DIV_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] STEP_ONE    = STEP_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0]  DEF_DIV_RAW = DIV_WIDTH'(DEFAULT_DIV);
  // A zero divider would never produce a pulse, so it is promoted to 1.
  localparam logic [DIV_WIDTH-1:0]  DEF_DIV_EFF = (DEF_DIV_RAW == '0) ? DIV_ONE : DEF_DIV_RAW;

  state_t                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    div_q, div_d;
  logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
  logic [STEP_WIDTH-1:0]   rem_q, rem_d;
  logic                    ce_q, ce_d;
  logic                    ack_q, ack_d;
  logic                    done_q, done_d;
  logic [31:0]             tick_q, tick_d;

  logic                    any_req;
  logic                    cnt_hit;
  logic                    step_finish;
  logic                    state_change;

  // Next-state, divider counter and pulse generation.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    tick_d       = tick_q;
    ce_d         = 1'b0;
    ack_d        = 1'b0;
    done_d       = 1'b0;
    any_req      = halt_req_i | step_req_i | resume_req_i;
    cnt_hit      = (cnt_q == (div_q - DIV_ONE));
    // The pulse that consumed the last step has already been issued; leave now.
    step_finish  = (state_q == ST_STEP) && (rem_q == '0);
    state_change = 1'b0;

    // Any accepted request is acknowledged, even when it changes nothing.
    ack_d = any_req;

    // Halt outranks everything; step and resume only act from HALT.
    if (halt_req_i) begin
      if (state_q != ST_HALT) begin
        state_d      = ST_HALT;
        state_change = 1'b1;
      end
      rem_d = '0;
    end else if (state_q == ST_HALT) begin
      if (step_req_i) begin
        state_d      = ST_STEP;
        rem_d        = (step_count_i == '0) ? STEP_ONE : step_count_i;
        state_change = 1'b1;
      end else if (resume_req_i) begin
        state_d      = ST_RUN;
        state_change = 1'b1;
      end
    end else if (step_finish) begin
      state_d      = ST_HALT;
      done_d       = 1'b1;
      state_change = 1'b1;
    end

    if (div_load_i) begin
      div_d = (div_i == '0) ? DIV_ONE : div_i;
    end

    // A state change or divider load restarts the period; otherwise count while not halted.
    if (state_change || div_load_i) begin
      cnt_d = '0;
    end else if (state_q != ST_HALT) begin
      if (cnt_hit) begin
        cnt_d  = '0;
        ce_d   = 1'b1;
        tick_d = tick_q + 32'd1;
        if (state_q == ST_STEP) begin
          rem_d = rem_q - STEP_ONE;
        end
      end else begin
        cnt_d = cnt_q + DIV_ONE;
      end
    end
  end

  // State and output registers with synchronous reset into RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      div_q   <= DEF_DIV_EFF;
      cnt_q   <= '0;
      rem_q   <= '0;
      ce_q    <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      ce_q    <= ce_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
    end
  end

  assign cpu_ce_o     = ce_q;
  assign ack_o        = ack_q;
  assign step_done_o  = done_q;
  assign halted_o     = (state_q == ST_HALT);
  assign tick_count_o = tick_q;

endmodule

// File: tb/tb_cpu_run_control.sv
// Bench for cpu_run_control: directed requests, expected events queued per output.
// Latency: expectations are stated in absolute cycle numbers derived by hand.
// Backpressure: each request is held for exactly one cycle.
module tb_cpu_run_control;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] div_i = '0;
  logic        div_load_i = 1'b0;
  logic        halt_req_i = 1'b0;
  logic        resume_req_i = 1'b0;
  logic        step_req_i = 1'b0;
  logic [15:0] step_count_i = '0;
  logic        cpu_ce_o;
  logic        ack_o;
  logic        halted_o;
  logic        step_done_o;
  logic [31:0] tick_count_o;

  cpu_run_control #(
    .DIV_WIDTH  (32),
    .DEFAULT_DIV(4),
    .STEP_WIDTH (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .div_i       (div_i),
    .div_load_i  (div_load_i),
    .halt_req_i  (halt_req_i),
    .resume_req_i(resume_req_i),
    .step_req_i  (step_req_i),
    .step_count_i(step_count_i),
    .cpu_ce_o    (cpu_ce_o),
    .ack_o       (ack_o),
    .halted_o    (halted_o),
    .step_done_o (step_done_o),
    .tick_count_o(tick_count_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] tick;
  } ce_exp_t;

  typedef struct {
    int   cyc;
    logic halted;
  } ev_exp_t;

  ce_exp_t exp_ce[$];
  ev_exp_t exp_ack[$];
  ev_exp_t exp_done[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: pulse seen at cycle %0d, required none", name, cyc);
  endtask

  // Monitor: pops the matching expectation whenever an event output is high.
  always @(negedge clk_i) begin : mon
    ce_exp_t ec;
    ev_exp_t ev;
    if (!rst_i) begin
      if (cpu_ce_o) begin
        if (exp_ce.size() == 0) unexpected("ce_unexpected");
        else begin
          ec = exp_ce.pop_front();
          check("ce_cycle", cyc, ec.cyc);
          check("ce_tick", tick_count_o, ec.tick);
        end
      end
      if (ack_o) begin
        if (exp_ack.size() == 0) unexpected("ack_unexpected");
        else begin
          ev = exp_ack.pop_front();
          check("ack_cycle", cyc, ev.cyc);
          check("ack_halted", {31'd0, halted_o}, {31'd0, ev.halted});
        end
      end
      if (step_done_o) begin
        if (exp_done.size() == 0) unexpected("done_unexpected");
        else begin
          ev = exp_done.pop_front();
          check("done_cycle", cyc, ev.cyc);
          check("done_halted", {31'd0, halted_o}, {31'd0, ev.halted});
        end
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk_i);
  endtask

  function automatic void push_ce(input int c, input logic [31:0] tk);
    ce_exp_t e;
    e.cyc  = c;
    e.tick = tk;
    exp_ce.push_back(e);
  endfunction

  function automatic void push_ev(input bit is_done, input int c, input logic h);
    ev_exp_t e;
    e.cyc    = c;
    e.halted = h;
    if (is_done) exp_done.push_back(e);
    else         exp_ack.push_back(e);
  endfunction

  // One-cycle request; a single ack is expected in the following cycle.
  task automatic do_req(input bit h, input bit s, input bit r, input logic [15:0] cnt,
                        input logic exp_halted);
    halt_req_i   = h;
    step_req_i   = s;
    resume_req_i = r;
    step_count_i = cnt;
    push_ev(1'b0, cyc + 1, exp_halted);
    @(negedge clk_i);
    halt_req_i   = 1'b0;
    step_req_i   = 1'b0;
    resume_req_i = 1'b0;
  endtask

  task automatic load_div(input logic [31:0] d);
    div_i      = d;
    div_load_i = 1'b1;
    @(negedge clk_i);
    div_load_i = 1'b0;
  endtask

  initial begin : wdog
    #100000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int m, t, r;
    repeat (3) @(negedge clk_i);

    // Reset state, divider 4: pulses at m+4, m+8, m+12.
    m = cyc;
    check("rst_ce", {31'd0, cpu_ce_o}, 32'd0);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_done", {31'd0, step_done_o}, 32'd0);
    check("rst_halted", {31'd0, halted_o}, 32'd0);
    check("rst_tick", tick_count_o, 32'd0);
    rst_i = 1'b0;
    push_ce(m + 4, 32'd1);
    push_ce(m + 8, 32'd2);
    push_ce(m + 12, 32'd3);

    // Halt when counter==3 suppresses the m+16 pulse; silence for 20 cycles.
    goto(m + 15);
    do_req(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    goto(m + 36);

    // Divider 2, step 3.
    load_div(32'd2);
    t = cyc + 1;
    push_ce(t + 2, 32'd4);
    push_ce(t + 4, 32'd5);
    push_ce(t + 6, 32'd6);
    push_ev(1'b1, t + 7, 1'b1);
    do_req(1'b0, 1'b1, 1'b0, 16'd3, 1'b0);
    goto(t + 10);

    // Step count 0 behaves as 1.
    t = cyc + 1;
    push_ce(t + 2, 32'd7);
    push_ev(1'b1, t + 3, 1'b1);
    do_req(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    goto(t + 6);

    // Halt and step together from HALT: halt wins, one ack.
    do_req(1'b1, 1'b1, 1'b0, 16'd4, 1'b1);
    repeat (3) @(negedge clk_i);
    check("hs_halted", {31'd0, halted_o}, 32'd1);

    // Step 5 aborted by halt after the 2nd pulse.
    t = cyc + 1;
    push_ce(t + 2, 32'd8);
    push_ce(t + 4, 32'd9);
    do_req(1'b0, 1'b1, 1'b0, 16'd5, 1'b0);
    goto(t + 4);
    do_req(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    goto(t + 15);
    check("abort_tick", tick_count_o, 32'd9);

    // Resume, then load divider 0: a pulse every cycle; halt suppresses the next.
    r = cyc + 1;
    do_req(1'b0, 1'b0, 1'b1, 16'd0, 1'b0);
    div_i      = 32'd0;
    div_load_i = 1'b1;
    push_ce(r + 2, 32'd10);
    push_ce(r + 3, 32'd11);
    push_ce(r + 4, 32'd12);
    push_ce(r + 5, 32'd13);
    @(negedge clk_i);
    div_load_i = 1'b0;
    goto(r + 5);
    do_req(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    goto(r + 10);

    // Tick counter wrap from a forced value.
    force dut.tick_q = 32'hFFFF_FFFE;
    @(negedge clk_i);
    release dut.tick_q;
    @(negedge clk_i);
    check("forced_tick", tick_count_o, 32'hFFFF_FFFE);
    t = cyc + 1;
    push_ce(t + 1, 32'hFFFF_FFFF);
    push_ce(t + 2, 32'd0);
    push_ce(t + 3, 32'd1);
    push_ev(1'b1, t + 4, 1'b1);
    do_req(1'b0, 1'b1, 1'b0, 16'd3, 1'b0);
    goto(t + 7);

    // Reset in the middle of a step.
    load_div(32'd3);
    t = cyc + 1;
    push_ce(t + 3, 32'd2);
    do_req(1'b0, 1'b1, 1'b0, 16'd5, 1'b0);
    goto(t + 4);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("mid_rst_ce", {31'd0, cpu_ce_o}, 32'd0);
    check("mid_rst_ack", {31'd0, ack_o}, 32'd0);
    check("mid_rst_done", {31'd0, step_done_o}, 32'd0);
    check("mid_rst_halted", {31'd0, halted_o}, 32'd0);
    check("mid_rst_tick", tick_count_o, 32'd0);

    // Every expected event must have been observed.
    check("ce_left", exp_ce.size(), 32'd0);
    check("ack_left", exp_ack.size(), 32'd0);
    check("done_left", exp_done.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
